// File: rtl/cpu_timing_gen.sv
//------------------------------------------------------------------------------
// cpu_timing_gen : opcode capture, two-cycle/one-byte classify, T1..T7 stepping
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cpu_timing_gen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cycleEnd_IN,
  input  logic       rdy_IN,
  input  logic [7:0] preDecode_IN,
  input  logic       endInstr_IN,
  input  logic       intPending_IN,
  output logic [2:0] tState_OUT,
  output logic       sync_OUT,
  output logic [7:0] ir_OUT,
  output logic       twoCycle_OUT,
  output logic       oneByte_OUT,
  output logic       lastCycle_OUT,
  output logic       intCycle_OUT
);

  typedef enum logic [2:0] {
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5,
    T6 = 3'd6,
    T7 = 3'd7
  } state_t;

  localparam logic [7:0] c_BRK = 8'h00;

  state_t     r_state;
  logic [7:0] r_ir;
  logic       r_two_cycle;
  logic       r_one_byte;
  logic       r_int_cycle;

  logic w_advance;
  logic w_imm;
  logic w_one_byte;
  logic w_two_cycle;
  logic w_last;

  assign w_advance = cycleEnd_IN & rdy_IN;

  assign w_imm = (preDecode_IN[4:0] == 5'b01001) ||
                 (preDecode_IN[7] && (preDecode_IN[7:5] != 3'b100) &&
                  ((preDecode_IN[4:0] == 5'b00000) || (preDecode_IN[4:0] == 5'b00010)));

  assign w_one_byte = (preDecode_IN[3:0] == 4'b1000) || (preDecode_IN[3:0] == 4'b1010);

  // PHP/PLP/PHA/PLA (08/28/48/68) are one-byte but take more than two cycles
  assign w_two_cycle = w_imm ||
                       (w_one_byte && !(!preDecode_IN[7] && !preDecode_IN[4] &&
                                        (preDecode_IN[3:0] == 4'b1000)));

  assign w_last = ((r_state == T2) && r_two_cycle) ||
                  ((r_state != T1) && endInstr_IN) ||
                  (r_state == T7);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= T1;
      r_ir        <= c_BRK;
      r_two_cycle <= 1'b0;
      r_one_byte  <= 1'b0;
      r_int_cycle <= 1'b0;
    end else if (w_advance) begin
      case (r_state)
        T1: begin
          if (intPending_IN) begin
            r_ir        <= c_BRK;
            r_int_cycle <= 1'b1;
            r_two_cycle <= 1'b0;
            r_one_byte  <= 1'b0;
          end else begin
            r_ir        <= preDecode_IN;
            r_int_cycle <= 1'b0;
            r_two_cycle <= w_two_cycle;
            r_one_byte  <= w_one_byte;
          end
          r_state <= T2;
        end
        T7:      r_state <= T1;
        default: r_state <= w_last ? T1 : state_t'(r_state + 3'd1);
      endcase
    end
  end

  assign tState_OUT    = r_state;
  assign sync_OUT      = (r_state == T1);
  assign ir_OUT        = r_ir;
  assign twoCycle_OUT  = r_two_cycle;
  assign oneByte_OUT   = r_one_byte;
  assign lastCycle_OUT = w_last;
  assign intCycle_OUT  = r_int_cycle;

endmodule

`default_nettype wire
